// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment scan driver: digit count, the
// segment vector type, the all-off pattern and the hex decode table.
// Segment vectors are active-low, ordered gfedcba (bit 0 = segment a).
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns for hex 0..F (lowercase b and d shapes).
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
// Purely combinational hex-nibble to active-low 7-segment decoder.
// Ports:
//   hex_i : 4-bit nibble to display
//   seg_o : active-low segment pattern, gfedcba
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame (at the slot 3 -> slot 0 wrap) so a
// frame never mixes old and new values; each digit slot lasts CLK_DIV clocks.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   digit0-3 : nibbles, digit0 rightmost (an[0]), digit3 leftmost (an[3])
//   dp_en    : per-digit decimal point enable
//   blank_lz : enable leading-zero blanking
//   an       : active-low anode selects
//   seg      : active-low segments, seg[0]=a .. seg[6]=g
//   dp_n     : active-low decimal point
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            digit0,
  input  logic [3:0]            digit1,
  input  logic [3:0]            digit2,
  input  logic [3:0]            digit3,
  input  logic [NUM_DIGITS-1:0] dp_en,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp_n
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]           pre_q, pre_d;
  logic [1:0]                 idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]      dpen_q, dpen_d;
  logic                       blank_q, blank_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  seg_t                       seg_q, seg_d;
  logic                       dp_n_q, dp_n_d;

  logic tick;
  logic frame_wrap;
  logic slot_blank;
  logic z3, z2, z1;
  seg_t dec_seg;

  hex_to_7seg u_dec (
    .hex_i (dig_q[idx_q]),
    .seg_o (dec_seg)
  );

  assign tick       = (pre_q == PRE_LAST);
  assign frame_wrap = tick && (idx_q == 2'd3);

  // Zero flags of the snapshotted digits, used for leading-zero blanking.
  assign z3 = (dig_q[3] == 4'h0);
  assign z2 = (dig_q[2] == 4'h0);
  assign z1 = (dig_q[1] == 4'h0);

  always_comb begin
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    dig_d      = dig_q;
    dpen_d     = dpen_q;
    blank_d    = blank_q;
    slot_blank = 1'b0;

    if (frame_wrap) begin
      dig_d   = {digit3, digit2, digit1, digit0};
      dpen_d  = dp_en;
      blank_d = blank_lz;
    end

    // A digit is blanked only when it and every digit to its left are zero;
    // the rightmost digit always shows so a zero value is still visible.
    unique case (idx_q)
      2'd3:    slot_blank = blank_q && z3;
      2'd2:    slot_blank = blank_q && z3 && z2;
      2'd1:    slot_blank = blank_q && z3 && z2 && z1;
      default: slot_blank = 1'b0;
    endcase

    an_d   = slot_blank ? '1        : ~(4'b0001 << idx_q);
    seg_d  = slot_blank ? SEG_BLANK : dec_seg;
    dp_n_d = slot_blank ? 1'b1      : ~dpen_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dpen_q  <= '0;
      blank_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_n_q  <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dpen_q  <= dpen_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with CLK_DIV=4 (16-cycle frames).
// Frames after reset release: 1 zeros, 2 F/A/1/8 (inputs changed mid-frame),
// 3 all fives, 4 blanking 0005, 5 blanking 0700, 6 decimal point, 7 reset.
module tb_seg7_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_en;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;

  int tests;
  int fails;

  seg7_scan_driver #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .dp_en    (dp_en),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp_n     (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_check(input string tag, input logic [3:0] ea,
                            input logic [6:0] es, input logic ed);
    @(posedge clk);
    #1;
    tests++;
    assert ({an, seg, dp_n} === {ea, es, ed})
    else begin
      fails++;
      $error("FAIL %s: observed an=%b seg=%h dp_n=%b, expected an=%b seg=%h dp_n=%b",
             tag, an, seg, dp_n, ea, es, ed);
    end
  endtask

  task automatic check_slot(input string tag, input logic [3:0] ea,
                            input logic [6:0] es, input logic ed);
    for (int c = 0; c < 4; c++) step_check(tag, ea, es, ed);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    digit0   = 4'h0;
    digit1   = 4'h0;
    digit2   = 4'h0;
    digit3   = 4'h0;
    dp_en    = 4'b0000;
    blank_lz = 1'b0;

    step_check("reset_c1", 4'b1111, 7'h7F, 1'b1);
    step_check("reset_c2", 4'b1111, 7'h7F, 1'b1);

    reset  = 1'b0;
    digit3 = 4'hF;
    digit2 = 4'hA;
    digit1 = 4'h1;
    digit0 = 4'h8;

    // Frame 1: shadows still zero.
    check_slot("f1_s0", 4'b1110, 7'h40, 1'b1);
    check_slot("f1_s1", 4'b1101, 7'h40, 1'b1);
    check_slot("f1_s2", 4'b1011, 7'h40, 1'b1);
    check_slot("f1_s3", 4'b0111, 7'h40, 1'b1);

    // Frame 2: F,A,1,8; inputs switch to 5555 during slot 2.
    check_slot("scan_s0", 4'b1110, 7'h00, 1'b1);
    check_slot("scan_s1", 4'b1101, 7'h79, 1'b1);
    step_check("scan_s2", 4'b1011, 7'h08, 1'b1);
    digit3 = 4'h5;
    digit2 = 4'h5;
    digit1 = 4'h5;
    digit0 = 4'h5;
    for (int c = 0; c < 3; c++) step_check("tear_s2", 4'b1011, 7'h08, 1'b1);
    check_slot("tear_s3", 4'b0111, 7'h0E, 1'b1);

    // Frame 3: all fives; load 0,0,0,5 with blanking for the next frame.
    blank_lz = 1'b1;
    digit3   = 4'h0;
    digit2   = 4'h0;
    digit1   = 4'h0;
    digit0   = 4'h5;
    check_slot("five_s0", 4'b1110, 7'h12, 1'b1);
    check_slot("five_s1", 4'b1101, 7'h12, 1'b1);
    check_slot("five_s2", 4'b1011, 7'h12, 1'b1);
    check_slot("five_s3", 4'b0111, 7'h12, 1'b1);

    // Frame 4: only digit0 lit.
    digit3 = 4'h0;
    digit2 = 4'h7;
    digit1 = 4'h0;
    digit0 = 4'h0;
    check_slot("lz1_s0", 4'b1110, 7'h12, 1'b1);
    check_slot("lz1_s1", 4'b1111, 7'h7F, 1'b1);
    check_slot("lz1_s2", 4'b1111, 7'h7F, 1'b1);
    check_slot("lz1_s3", 4'b1111, 7'h7F, 1'b1);

    // Frame 5: 0,7,0,0 -> only the leftmost slot blank.
    blank_lz = 1'b0;
    dp_en    = 4'b0100;
    digit3   = 4'hF;
    digit2   = 4'hA;
    digit1   = 4'h1;
    digit0   = 4'h8;
    check_slot("lz2_s0", 4'b1110, 7'h40, 1'b1);
    check_slot("lz2_s1", 4'b1101, 7'h40, 1'b1);
    check_slot("lz2_s2", 4'b1011, 7'h78, 1'b1);
    check_slot("lz2_s3", 4'b1111, 7'h7F, 1'b1);

    // Frame 6: decimal point on digit 2 only.
    check_slot("dp_s0", 4'b1110, 7'h00, 1'b1);
    check_slot("dp_s1", 4'b1101, 7'h79, 1'b1);
    check_slot("dp_s2", 4'b1011, 7'h08, 1'b0);
    check_slot("dp_s3", 4'b0111, 7'h0E, 1'b1);

    // Frame 7: reset for one cycle during slot 2.
    check_slot("pre_rst_s0", 4'b1110, 7'h00, 1'b1);
    check_slot("pre_rst_s1", 4'b1101, 7'h79, 1'b1);
    step_check("pre_rst_s2", 4'b1011, 7'h08, 1'b0);
    reset = 1'b1;
    step_check("midrst", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0;
    check_slot("post_rst_s0", 4'b1110, 7'h40, 1'b1);
    step_check("post_rst_s1", 4'b1101, 7'h40, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a 4-digit, common-anode 7-segment display. It consumes the four 4-bit nibble outputs of the free-running N-bit counter stage (least-significant nibble on `digit0`). It snapshots the nibbles once per scan frame so the display does not tear, then rotates through the digits at a programmable rate. Outputs are active-low anode and segment lines for direct connection to board pins.

## Interface
- `CLK_DIV`, default 100000: clk cycles per digit slot (≈1 kHz digit rate at 100 MHz); legal range ≥ 2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `digit0` input 4: nibble for the rightmost digit, driven on `an[0]`.
- `digit1` input 4: nibble driven on `an[1]`.
- `digit2` input 4: nibble driven on `an[2]`.
- `digit3` input 4: nibble for the leftmost digit, driven on `an[3]`.
- `dp_en` input 4: per-digit decimal-point enable; bit i controls digit i.
- `blank_lz` input 1: enables leading-zero blanking.
- `an` output 4: anode selects, active-low, one-hot-low when a digit is lit.
- `seg` output 7: segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp_n` output 1: decimal point, active-low.

## Operation
- Prescaler `pre` counts 0..CLK_DIV-1 and wraps. `tick` = (`pre`==CLK_DIV-1).
- Slot index `idx` (2 bits) advances 0→1→2→3→0 on `tick`.
- Shadow registers hold `digit0`..`digit3`, `dp_en` and `blank_lz`.
  - They load only on the edge where `tick` is high and `idx`==3, i.e. the frame wrap.
  - Input changes at any other time have no visible effect until the next frame.
- Leading-zero blanking (shadow `blank_lz`=1), evaluated on shadow values:
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digit3 and digit2 are both 0.
  - digit1 is blanked if digit3, digit2 and digit1 are all 0.
  - digit0 is never blanked.
- A blanked slot drives `an`=4'b1111, `seg`=7'h7F and `dp_n`=1.
- Unblanked slot i drives: `an` with bit i low and all other bits high; `seg` = decode(shadow digit i); `dp_n` = ~shadow `dp_en`[i].
- Decode values, active-low gfedcba: 0→7'h40, 1→7'h79, 5→7'h12, 8→7'h00, A→7'h08, F→7'h0E. All 16 hex values are decoded.
- `an`, `seg` and `dp_n` are registered. They reflect the `idx` and shadow state of the previous cycle.

## Timing
- Reset values: `pre`=0, `idx`=0, shadows=0, `an`=4'b1111, `seg`=7'h7F, `dp_n`=1.
- First edge after `reset` deasserts: `an`=4'b1110, `seg`=7'h40 (shadow zero, slot 0).
- Each slot lasts exactly CLK_DIV cycles. A full frame lasts 4·CLK_DIV cycles.
- Latency from a new frame's snapshot to its slot-0 display is 1 cycle; the outputs register on the edge after the capture edge.
- Input-to-display latency is therefore between 1 and 4·CLK_DIV cycles.
- Reset asserted mid-frame: on that edge all state returns to reset values, and scanning restarts at slot 0 with zeroed shadows.
- `pre` width is $clog2(CLK_DIV). Wrap happens by compare, not by overflow.

## Structure
- Package `seg7_pkg` holds:
  - `NUM_DIGITS`=4;
  - typedef `seg_t` (logic [6:0]);
  - constant `SEG_BLANK`=7'h7F;
  - the 16-entry active-low decode constant array.
- Sub-module `hex_to_7seg` is purely combinational: 4-bit input to `seg_t` output, driven from the package array.
- The top module contains the prescaler, the slot index, the shadow registers, the blanking logic and the output registers.

## Test plan
All scenarios use `CLK_DIV`=4.
- Reset: hold `reset` 2 cycles → `an`=1111, `seg`=7F, `dp_n`=1. First cycle after release → `an`=1110, `seg`=40.
- Normal scan: digit3..0 = F,A,1,8, `dp_en`=0, `blank_lz`=0. After the first all-zero frame, expect each slot for 4 cycles:
  - `an`=1110, `seg`=00
  - `an`=1101, `seg`=79
  - `an`=1011, `seg`=08
  - `an`=0111, `seg`=0E
- Tearing: change inputs to all 5 during slot 2 → slots 2 and 3 still show the old values. The next frame shows `seg`=12 in every slot.
- Leading-zero blanking, `blank_lz`=1:
  - digits 0,0,0,5 → slots 1–3 give `an`=1111, `seg`=7F; slot 0 gives `seg`=12.
  - digits 0,7,0,0 → only slot 3 is blank; slots 1 and 0 show `seg`=40.
- Decimal point: `dp_en`=0100 → `dp_n`=0 only while `an`=1011; `dp_n`=1 in all other slots.
- Mid-frame reset: assert `reset` 1 cycle during slot 2 → next edge gives `an`=1111, then slot 0 with `seg`=40 for 4 cycles.
